phase_current_conditioner: RTL and testbench

Sits directly downstream of the SPI ADC current-acquisition block. It consumes the raw 12-bit unsigned phase-U/V codes and their acquire-done strobe. At startup it calibrates the zero-current offset of each channel by averaging, then turns each sample pair into signed offset-corrected currents Iu, Iv and derives Iw = -(Iu+Iv). It also raises a sticky overcurrent flag for the FOC core and the PWM shutdown logic.

---
 rtl/phase_current_conditioner_pkg.sv | 29 ++
 rtl/phase_current_conditioner_offset_cal_acc.sv | 42 ++++
 rtl/phase_current_conditioner.sv | 141 ++++++++++++++
 tb/tb_phase_current_conditioner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/phase_current_conditioner_pkg.sv
// Shared definitions for the phase-current conditioner: FSM encoding,
// default datapath parameters and width helpers.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } fcState_t;

  localparam int DATA_W    = 12;
  localparam int CAL_SHIFT = 6;
  localparam int MID_CODE  = 2048;
  localparam int CAL_TOL   = 200;
  localparam int OC_LIMIT  = 1800;

  function automatic int rawWidth(input int w);
    return w;
  endfunction

  function automatic int curWidth(input int w);
    return w + 1;
  endfunction

  function automatic int iwWidth(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/phase_current_conditioner_offset_cal_acc.sv
// Per-channel calibration accumulator: sums raw codes, averages the
// running sum including the current sample, and checks it against the window.
module offset_cal_acc
  import fc_pkg::*;
#(
  parameter int DATA_W    = fc_pkg::DATA_W,
  parameter int CAL_SHIFT = fc_pkg::CAL_SHIFT,
  parameter int MID_CODE  = fc_pkg::MID_CODE,
  parameter int CAL_TOL   = fc_pkg::CAL_TOL
) (
  input  logic                           iClk,
  input  logic                           iRst_n,
  input  logic                           iClear,
  input  logic                           iAdd,
  input  logic [rawWidth(DATA_W)-1:0]    iRaw,
  output logic [DATA_W-1:0]              oOff,
  output logic                           oInTol
);

  localparam int ACC_W = DATA_W + CAL_SHIFT;
  localparam logic [DATA_W-1:0] TOL_LO = DATA_W'(MID_CODE - CAL_TOL);
  localparam logic [DATA_W-1:0] TOL_HI = DATA_W'(MID_CODE + CAL_TOL);

  logic [ACC_W-1:0] accReg;
  logic [ACC_W-1:0] accSum;

  // The average includes the sample arriving this cycle, so the final event counts.
  assign accSum = accReg + ACC_W'(iRaw);
  assign oOff   = accSum[ACC_W-1:CAL_SHIFT];
  assign oInTol = (oOff >= TOL_LO) && (oOff <= TOL_HI);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      accReg <= '0;
    end else if (iClear) begin
      accReg <= '0;
    end else if (iAdd) begin
      accReg <= accSum;
    end
  end

endmodule

// File: rtl/phase_current_conditioner.sv
// Offset calibration, signed current conversion with derived Iw, and sticky
// overcurrent detection for the phase-U/V ADC sample stream.
module phase_current_conditioner
  import fc_pkg::*;
#(
  parameter int DATA_W    = fc_pkg::DATA_W,
  parameter int CAL_SHIFT = fc_pkg::CAL_SHIFT,
  parameter int MID_CODE  = fc_pkg::MID_CODE,
  parameter int CAL_TOL   = fc_pkg::CAL_TOL,
  parameter int OC_LIMIT  = fc_pkg::OC_LIMIT
) (
  input  logic                                iClk,
  input  logic                                iRst_n,
  input  logic                                iCal_start,
  input  logic                                iSample_valid,
  input  logic        [rawWidth(DATA_W)-1:0]  iIu_raw,
  input  logic        [rawWidth(DATA_W)-1:0]  iIv_raw,
  input  logic                                iOc_clear,
  output logic signed [curWidth(DATA_W)-1:0]  oIu,
  output logic signed [curWidth(DATA_W)-1:0]  oIv,
  output logic signed [iwWidth(DATA_W)-1:0]   oIw,
  output logic                                oValid,
  output logic                                oCal_busy,
  output logic                                oCal_done,
  output logic                                oCal_fault,
  output logic                                oOvercurrent
);

  localparam int CUR_W = curWidth(DATA_W);
  localparam int IW_W  = iwWidth(DATA_W);
  localparam logic [CAL_SHIFT:0] CAL_LAST = (CAL_SHIFT + 1)'((1 << CAL_SHIFT) - 1);
  localparam logic signed [IW_W-1:0] OC_POS = IW_W'(OC_LIMIT);

  fcState_t state;
  logic prevSample, prevCal;
  logic sampleEvt, calEvt, calAdd, runEvt, fire;
  logic [CAL_SHIFT:0] cnt;
  logic [DATA_W-1:0] offU, offV, avgU, avgV;
  logic inTolU, inTolV;
  logic s1Valid;
  logic signed [CUR_W-1:0] dU, dV;
  logic signed [IW_W-1:0] sU, sV, iwNext;
  logic ocHit;

  assign sampleEvt = iSample_valid & ~prevSample;
  assign calEvt    = iCal_start & ~prevCal;
  assign calAdd    = sampleEvt && (state == ST_CAL) && !calEvt;
  assign runEvt    = sampleEvt && (state == ST_RUN) && !calEvt;
  // A restart landing on the stage-2 cycle discards the in-flight sample.
  assign fire      = s1Valid && (state == ST_RUN) && !calEvt;

  offset_cal_acc #(.DATA_W(DATA_W), .CAL_SHIFT(CAL_SHIFT), .MID_CODE(MID_CODE), .CAL_TOL(CAL_TOL))
    uAccU (.iClk(iClk), .iRst_n(iRst_n), .iClear(calEvt), .iAdd(calAdd),
           .iRaw(iIu_raw), .oOff(avgU), .oInTol(inTolU));

  offset_cal_acc #(.DATA_W(DATA_W), .CAL_SHIFT(CAL_SHIFT), .MID_CODE(MID_CODE), .CAL_TOL(CAL_TOL))
    uAccV (.iClk(iClk), .iRst_n(iRst_n), .iClear(calEvt), .iAdd(calAdd),
           .iRaw(iIv_raw), .oOff(avgV), .oInTol(inTolV));

  assign sU     = {dU[CUR_W-1], dU};
  assign sV     = {dV[CUR_W-1], dV};
  assign iwNext = -(sU + sV);
  assign ocHit  = (sU > OC_POS) || (sU < -OC_POS) ||
                  (sV > OC_POS) || (sV < -OC_POS) ||
                  (iwNext > OC_POS) || (iwNext < -OC_POS);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      offU       <= DATA_W'(MID_CODE);
      offV       <= DATA_W'(MID_CODE);
      oCal_busy  <= 1'b0;
      oCal_done  <= 1'b0;
      oCal_fault <= 1'b0;
    end else if (calEvt) begin
      state      <= ST_CAL;
      cnt        <= '0;
      oCal_busy  <= 1'b1;
      oCal_done  <= 1'b0;
      oCal_fault <= 1'b0;
    end else begin
      case (state)
        ST_CAL: begin
          if (sampleEvt) begin
            if (cnt == CAL_LAST) begin
              oCal_busy <= 1'b0;
              if (inTolU && inTolV) begin
                offU      <= avgU;
                offV      <= avgV;
                oCal_done <= 1'b1;
                state     <= ST_RUN;
              end else begin
                oCal_fault <= 1'b1;
                state      <= ST_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      prevSample   <= 1'b0;
      prevCal      <= 1'b0;
      s1Valid      <= 1'b0;
      dU           <= '0;
      dV           <= '0;
      oIu          <= '0;
      oIv          <= '0;
      oIw          <= '0;
      oValid       <= 1'b0;
      oOvercurrent <= 1'b0;
    end else begin
      prevSample <= iSample_valid;
      prevCal    <= iCal_start;
      s1Valid    <= runEvt;
      if (runEvt) begin
        dU <= $signed({1'b0, iIu_raw}) - $signed({1'b0, offU});
        dV <= $signed({1'b0, iIv_raw}) - $signed({1'b0, offV});
      end
      oValid <= fire;
      if (fire) begin
        oIu <= dU;
        oIv <= dV;
        oIw <= iwNext;
      end
      if (fire && ocHit) begin
        oOvercurrent <= 1'b1;
      end else if (iOc_clear) begin
        oOvercurrent <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_current_conditioner.sv
// Directed bench for phase_current_conditioner: calibration, conversion,
// overcurrent, fault, restart and asynchronous reset scenarios.
module tb_phase_current_conditioner;

  logic               iClk = 1'b0;
  logic               iRst_n = 1'b0;
  logic               iCal_start = 1'b0;
  logic               iSample_valid = 1'b0;
  logic        [11:0] iIu_raw = 12'd0;
  logic        [11:0] iIv_raw = 12'd0;
  logic               iOc_clear = 1'b0;
  logic signed [12:0] oIu;
  logic signed [12:0] oIv;
  logic signed [13:0] oIw;
  logic               oValid;
  logic               oCal_busy;
  logic               oCal_done;
  logic               oCal_fault;
  logic               oOvercurrent;

  int vectors = 0;
  int miscompares = 0;
  int validCount = 0;
  int vcSnap;

  phase_current_conditioner dut (
    .iClk(iClk), .iRst_n(iRst_n), .iCal_start(iCal_start),
    .iSample_valid(iSample_valid), .iIu_raw(iIu_raw), .iIv_raw(iIv_raw),
    .iOc_clear(iOc_clear), .oIu(oIu), .oIv(oIv), .oIw(oIw), .oValid(oValid),
    .oCal_busy(oCal_busy), .oCal_done(oCal_done), .oCal_fault(oCal_fault),
    .oOvercurrent(oOvercurrent)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oValid === 1'b1) validCount++;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulseCal();
    iCal_start = 1'b1;
    tick();
    iCal_start = 1'b0;
    tick();
  endtask

  task automatic event2(input int u, input int v);
    iIu_raw = 12'(u);
    iIv_raw = 12'(v);
    iSample_valid = 1'b1;
    tick();
    iSample_valid = 1'b0;
    tick();
  endtask

  task automatic calibrate(input int u, input int v, input int expOk);
    int vc0;
    vc0 = validCount;
    pulseCal();
    chk("cal_busy_start", int'(oCal_busy), 1);
    chk("cal_done_start", int'(oCal_done), 0);
    for (int i = 0; i < 63; i++) event2(u, v);
    chk("cal_busy_63", int'(oCal_busy), 1);
    event2(u, v);
    chk("cal_busy_end", int'(oCal_busy), 0);
    chk("cal_done_end", int'(oCal_done), expOk);
    chk("cal_fault_end", int'(oCal_fault), 1 - expOk);
    chk("cal_no_valid", validCount, vc0);
    $display("cal u=%0d v=%0d busy=%0b done=%0b fault=%0b", u, v, oCal_busy, oCal_done, oCal_fault);
  endtask

  task automatic runEvent(input int u, input int v, input int clr,
                          input int eu, input int ev, input int ew, input int eoc);
    iIu_raw = 12'(u);
    iIv_raw = 12'(v);
    iOc_clear = clr[0];
    iSample_valid = 1'b1;
    tick();
    chk("run_valid_s1", int'(oValid), 0);
    iSample_valid = 1'b0;
    tick();
    iOc_clear = 1'b0;
    chk("run_valid_s2", int'(oValid), 1);
    chk("run_iu", int'(oIu), eu);
    chk("run_iv", int'(oIv), ev);
    chk("run_iw", int'(oIw), ew);
    chk("run_oc", int'(oOvercurrent), eoc);
    tick();
    chk("run_valid_after", int'(oValid), 0);
    $display("run u=%0d v=%0d -> iu=%0d iv=%0d iw=%0d oc=%0b", u, v, oIu, oIv, oIw, oOvercurrent);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_iu", int'(oIu), 0);
    chk("rst_iw", int'(oIw), 0);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_busy", int'(oCal_busy), 0);
    chk("rst_done", int'(oCal_done), 0);
    chk("rst_fault", int'(oCal_fault), 0);
    chk("rst_oc", int'(oOvercurrent), 0);
    iRst_n = 1'b1;
    tick();

    event2(2150, 1940);
    tick();
    chk("idle_ignore", validCount, 0);

    calibrate(2050, 2040, 1);
    runEvent(2150, 1940, 0, 100, -100, 0, 0);
    runEvent(2050, 2040, 0, 0, 0, 0, 0);

    // Boundary and overcurrent behaviour.
    runEvent(3848, 2040, 0, 1798, 0, -1798, 0);
    runEvent(3850, 2040, 0, 1800, 0, -1800, 0);
    runEvent(3900, 2040, 0, 1850, 0, -1850, 1);
    runEvent(3900, 2040, 1, 1850, 0, -1850, 1);
    iOc_clear = 1'b1;
    tick();
    iOc_clear = 1'b0;
    chk("oc_cleared", int'(oOvercurrent), 0);
    runEvent(2950, 2941, 0, 900, 901, -1801, 1);
    iOc_clear = 1'b1;
    tick();
    iOc_clear = 1'b0;
    chk("oc_cleared2", int'(oOvercurrent), 0);
    runEvent(2049, 2039, 0, -1, -1, 2, 0);

    // Restart one cycle after a sample event drops the in-flight sample.
    vcSnap = validCount;
    iIu_raw = 12'd2500;
    iSample_valid = 1'b1;
    tick();
    iSample_valid = 1'b0;
    iCal_start = 1'b1;
    tick();
    chk("drop_valid", int'(oValid), 0);
    iCal_start = 1'b0;
    repeat (3) tick();
    chk("drop_count", validCount, vcSnap);
    chk("drop_hold_iu", int'(oIu), -1);
    chk("drop_busy", int'(oCal_busy), 1);

    for (int i = 0; i < 30; i++) event2(2100, 2100);
    calibrate(2000, 2000, 1);
    runEvent(2000, 2000, 0, 0, 0, 0, 0);
    runEvent(2100, 1900, 0, 100, -100, 0, 0);

    calibrate(2300, 2040, 0);
    vcSnap = validCount;
    event2(2300, 2040);
    tick();
    chk("fault_no_valid", validCount, vcSnap);
    chk("fault_done", int'(oCal_done), 0);

    calibrate(2248, 1848, 1);
    runEvent(2248, 1848, 0, 0, 0, 0, 0);

    // Asynchronous reset with a sample in stage 1.
    vcSnap = validCount;
    iIu_raw = 12'd2348;
    iSample_valid = 1'b1;
    tick();
    iSample_valid = 1'b0;
    iRst_n = 1'b0;
    #1;
    chk("arst_iu", int'(oIu), 0);
    chk("arst_done", int'(oCal_done), 0);
    repeat (3) tick();
    chk("arst_valid", validCount, vcSnap);
    iRst_n = 1'b1;
    tick();
    event2(2348, 1848);
    repeat (2) tick();
    chk("arst_ignore", validCount, vcSnap);
    chk("arst_busy", int'(oCal_busy), 0);
    chk("arst_iw", int'(oIw), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
